// File: rtl/uart_pkg.sv
// UART transmitter shared types: FSM state encoding, default bit period, frame constants.
// The PARITY state only exists when UART_TX_PARITY_EN is defined.
package uart_pkg;

   localparam int DEF_CLK_PER_BIT = 868;
   localparam int DATA_BITS       = 8;
   localparam int STOP_BITS       = 1;

`ifdef UART_TX_PARITY_EN
   typedef enum logic [2:0] {ST_IDLE, ST_START, ST_DATA, ST_PARITY, ST_STOP} state_t;
`else
   typedef enum logic [1:0] {ST_IDLE, ST_START, ST_DATA, ST_STOP} state_t;
`endif

endpackage

// File: rtl/uart_tx_if.sv
// Core-side byte push strobe plus the transmitter's serial line and status flags.
// No backpressure: the core watches full/overflow, pushes are never stalled.
interface uart_tx_if;

   logic [7:0] sdata;
   logic       tx_ready;
   logic       txd;
   logic       busy;
   logic       full;
   logic       overflow;

   modport master (output sdata, tx_ready, input txd, busy, full, overflow);
   modport slave  (input sdata, tx_ready, output txd, busy, full, overflow);

endinterface

// File: rtl/sync_fifo.sv
// Count-based synchronous FIFO, show-ahead head on rd_data; one-cycle write-to-visible latency.
// Writes while full and reads while empty are ignored; DEPTH must be a power of two.
module sync_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16
) (
   input  logic                     clk,
   input  logic                     rstn,
   input  logic                     wr_en,
   input  logic [WIDTH-1:0]         wr_data,
   input  logic                     rd_en,
   output logic [WIDTH-1:0]         rd_data,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     full,
   output logic                     empty
);

   localparam int AW = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign full    = (count == FULL_CNT);
   assign empty   = (count == '0);
   assign do_wr   = wr_en && !full;
   assign do_rd   = rd_en && !empty;
   assign rd_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr)
         mem[wr_ptr] <= wr_data;
   end

   // Pointers wrap naturally because DEPTH is a power of two
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_wr)
            wr_ptr <= wr_ptr + 1'b1;
         if (do_rd)
            rd_ptr <= rd_ptr + 1'b1;
         case ({do_wr, do_rd})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/uart_tx.sv
// Buffered 8N1 UART transmitter (8E1 with UART_TX_PARITY_EN); txd falls two edges after a push into an idle, empty unit.
// No backpressure: pushes while full are dropped and latch the sticky overflow flag.
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_PER_BIT = DEF_CLK_PER_BIT,
   parameter int FIFO_DEPTH  = 16
) (
   input  logic      clk,
   input  logic      rstn,
   uart_tx_if.slave  bus
);

   localparam int          CW        = $clog2(FIFO_DEPTH) + 1;
   localparam logic [15:0] BAUD_LAST = 16'(CLK_PER_BIT - 1);

   state_t        state;
   state_t        state_nxt;
   logic [15:0]   baud_cnt;
   logic [15:0]   baud_nxt;
   logic [2:0]    bit_cnt;
   logic [2:0]    bit_nxt;
   logic [7:0]    shreg;
   logic [7:0]    shreg_nxt;
   logic          txd_q;
   logic          line_nxt;
   logic          ovf_q;
   logic          push;
   logic          pop;
   logic          baud_end;
   logic          fifo_full;
   logic          fifo_empty;
   logic [7:0]    head;
   logic [CW-1:0] count;
`ifdef UART_TX_PARITY_EN
   logic          parity_q;
   logic          parity_nxt;
`endif

   // full is the pre-edge value, so a push while full drops even if IDLE pops this cycle
   assign push     = bus.tx_ready && !fifo_full;
   assign pop      = (state == ST_IDLE) && !fifo_empty;
   assign baud_end = (baud_cnt == BAUD_LAST);

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rstn    (rstn),
      .wr_en   (push),
      .wr_data (bus.sdata),
      .rd_en   (pop),
      .rd_data (head),
      .count   (count),
      .full    (fifo_full),
      .empty   (fifo_empty)
   );

   always_comb begin
      state_nxt = state;
      baud_nxt  = baud_cnt;
      bit_nxt   = bit_cnt;
      shreg_nxt = shreg;
      line_nxt  = 1'b1;
`ifdef UART_TX_PARITY_EN
      parity_nxt = parity_q;
`endif
      case (state)
         ST_IDLE: begin
            if (pop) begin
               shreg_nxt = head;
               baud_nxt  = '0;
               bit_nxt   = '0;
               state_nxt = ST_START;
`ifdef UART_TX_PARITY_EN
               parity_nxt = ^head;
`endif
            end
         end
         ST_START: begin
            line_nxt = 1'b0;
            if (baud_end) begin
               baud_nxt  = '0;
               state_nxt = ST_DATA;
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
         ST_DATA: begin
            line_nxt = shreg[0];
            if (baud_end) begin
               baud_nxt  = '0;
               shreg_nxt = {1'b0, shreg[7:1]};
               if (bit_cnt == 3'(DATA_BITS - 1)) begin
                  bit_nxt = '0;
`ifdef UART_TX_PARITY_EN
                  state_nxt = ST_PARITY;
`else
                  state_nxt = ST_STOP;
`endif
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
`ifdef UART_TX_PARITY_EN
         ST_PARITY: begin
            line_nxt = parity_q;
            if (baud_end) begin
               baud_nxt  = '0;
               state_nxt = ST_STOP;
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
`endif
         ST_STOP: begin
            if (baud_end) begin
               baud_nxt = '0;
               if (bit_cnt == 3'(STOP_BITS - 1)) begin
                  bit_nxt   = '0;
                  state_nxt = ST_IDLE;
               end else begin
                  bit_nxt = bit_cnt + 3'd1;
               end
            end else begin
               baud_nxt = baud_cnt + 16'd1;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   // txd registers the line level of the current state, trailing the FSM by one cycle
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state    <= ST_IDLE;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         txd_q    <= 1'b1;
         ovf_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
         parity_q <= 1'b0;
`endif
      end else begin
         state    <= state_nxt;
         baud_cnt <= baud_nxt;
         bit_cnt  <= bit_nxt;
         shreg    <= shreg_nxt;
         txd_q    <= line_nxt;
         if (bus.tx_ready && fifo_full)
            ovf_q <= 1'b1;
`ifdef UART_TX_PARITY_EN
         parity_q <= parity_nxt;
`endif
      end
   end

   assign bus.txd      = txd_q;
   assign bus.busy     = (state != ST_IDLE) || (count != '0);
   assign bus.full     = fifo_full;
   assign bus.overflow = ovf_q;

endmodule

// File: doc/uart_tx.md
UART_TX -- requirements
Module: uart_tx

Interface
REQ-001 Parameter CLK_PER_BIT, default 868, clock cycles per serial bit (100 MHz / 115200 baud); legal range 2..65535.
REQ-002 Parameter FIFO_DEPTH, default 16, byte entries in transmit buffer; power of two, 2..256.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 rstn  input  1  reset; asynchronous, active-low.
REQ-005 sdata  input  8  byte to transmit; sampled only when tx_ready is 1.
REQ-006 tx_ready  input  1  push strobe from core; one-cycle pulse per byte, no backpressure to core.
REQ-007 txd  output  1  serial line; idle high; registered.
REQ-008 busy  output  1  1 while a frame is in progress or the buffer is non-empty.
REQ-009 full  output  1  1 when the buffer holds FIFO_DEPTH bytes.
REQ-010 overflow  output  1  sticky; set when a push is dropped.

Function
REQ-011 Push: at a rising edge with tx_ready=1 and full=0, sdata SHALL be written to the buffer tail.
REQ-012 Push with full=1 SHALL be dropped and SHALL set overflow; the buffer is unchanged.
REQ-013 full is evaluated before any same-cycle pop; a push while full is dropped even if a pop occurs that cycle.
REQ-014 Simultaneous push and pop with 0 < count < FIFO_DEPTH SHALL leave count unchanged, with FIFO ordering preserved.
REQ-015 FSM states: IDLE, START, DATA, PARITY (only with macro), STOP.
REQ-016 IDLE: if the buffer is non-empty, pop the head into the shift register, clear the bit and baud counters, and go to START with txd<=0; otherwise keep txd=1.
REQ-017 Latency: a push into an empty buffer with FSM in IDLE SHALL cause txd to fall at the second rising edge after the edge that sampled tx_ready.
REQ-018 Each of START, DATA bits, PARITY and STOP SHALL hold txd for exactly CLK_PER_BIT cycles, timed by a baud counter counting 0..CLK_PER_BIT-1.
REQ-019 DATA: 8 bits, LSB first; after bit 7 go to PARITY (macro defined) or STOP.
REQ-020 STOP: one stop bit (txd=1); at its end go to IDLE, which may start the next frame on the following edge.
REQ-021 Back-to-back frames SHALL therefore be separated by exactly one extra idle clock cycle; no gaps longer than that while the buffer is non-empty.
REQ-022 busy SHALL equal (state != IDLE) OR (count != 0), registered-consistent with state and count.
REQ-023 overflow SHALL clear only on reset.

Reset
REQ-024 rstn=0 SHALL asynchronously force txd=1, state=IDLE, buffer empty (full=0), busy=0, overflow=0, counters 0.
REQ-025 Reset mid-frame SHALL abort the frame immediately; no partial frame resumes after reset release.
REQ-026 The first push is accepted on the first rising edge with rstn=1.

Configuration
REQ-027 Macro UART_TX_PARITY_EN defined: PARITY state inserted after bit 7, transmitting the even-parity bit (XOR of the 8 data bits); frame = 11 bit-times.
REQ-028 Macro undefined: no PARITY state or parity logic; frame = 10 bit-times.

Structure
REQ-029 Shared package uart_pkg SHALL hold the FSM state type, the default CLK_PER_BIT constant, and the frame-length constants (data bits = 8, stop bits = 1).
REQ-030 Buffer SHALL be a sub-module sync_fifo (parameterised width/depth, count-based full/empty); FSM, baud counter, shift register and parity logic reside in uart_tx.

Verification (CLK_PER_BIT=4, FIFO_DEPTH=4 unless stated)
REQ-031 Single byte 0x55 pushed at edge E -> txd low from E+2 for 4 cycles, then 1,0,1,0,1,0,1,0 for 4 cycles each, stop high 4 cycles; busy falls with return to IDLE.
REQ-032 Pushes of 0x01,0x02,0x03 on consecutive cycles -> three frames in order, each one cycle apart after stop; full never asserted.
REQ-033 Six pushes on consecutive cycles -> first popped, four buffered, full=1, sixth dropped, overflow=1 and stays 1; five frames transmitted.
REQ-034 rstn pulsed low during DATA bit 3 of 0xA5 with two bytes buffered -> txd=1 immediately, busy=0, no further frames.
REQ-035 UART_TX_PARITY_EN defined, byte 0x07 -> parity bit 1 between bit 7 and stop; byte 0x03 -> parity bit 0.
REQ-036 Push at the same edge IDLE pops a 3-entry buffer -> count stays 3, order intact, no overflow.
